// File: rtl/packer_frame_arbiter_if.sv
// rtl/packer_frame_arbiter_if.sv - requester, packer and drain-tracking signals of the frame arbiter
// slave is the arbiter side; master is the requester/packer side.
interface packer_frame_arbiter_if #(
  parameter int NUM_SRC     = 4,
  parameter int SRC_W       = 2,
  parameter int INPUT_WIDTH = 40
);

  logic [NUM_SRC-1:0]             src_valid;
  logic [NUM_SRC*INPUT_WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]             src_ready;
  logic                           pk_valid;
  logic [INPUT_WIDTH-1:0]         pk_data;
  logic                           pk_sof;
  logic                           pk_eof;
  logic                           pk_frame_done;
  logic                           drain_id_valid;
  logic [SRC_W-1:0]               drain_src_id;
  logic [1:0]                     banks_busy;
  logic                           err_underflow;

  modport slave (
    input  src_valid, src_data, pk_frame_done,
    output src_ready, pk_valid, pk_data, pk_sof, pk_eof,
           drain_id_valid, drain_src_id, banks_busy, err_underflow
  );

  modport master (
    output src_valid, src_data, pk_frame_done,
    input  src_ready, pk_valid, pk_data, pk_sof, pk_eof,
           drain_id_valid, drain_src_id, banks_busy, err_underflow
  );

endinterface

// File: rtl/packer_frame_arbiter.sv
// rtl/packer_frame_arbiter.sv - round-robin frame arbiter and ping-pong bank scheduler for the 40->66 packer
// Grants one requester per whole frame and remembers which source owns each undrained bank.
module packer_frame_arbiter #(
  parameter int NUM_SRC         = 4,
  parameter int SRC_W           = 2,
  parameter int INPUT_WIDTH     = 40,
  parameter int WORDS_PER_FRAME = 33,
  parameter int CNT_W           = 6
) (
  input logic                  clk,
  input logic                  reset_n,
  packer_frame_arbiter_if.slave bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(WORDS_PER_FRAME - 1);
  localparam logic [SRC_W:0]   NUM_SRC_W  = (SRC_W + 1)'(NUM_SRC);

  state_t                 r_state;
  state_t                 w_next_state;
  logic [SRC_W-1:0]       r_rr_ptr;
  logic [SRC_W-1:0]       r_grant;
  logic [CNT_W-1:0]       r_word_cnt;
  logic [1:0]             r_banks_busy;
  logic [SRC_W-1:0]       r_fifo_head;
  logic [SRC_W-1:0]       r_fifo_tail;
  logic                   r_err_underflow;

  logic                   w_found;
  logic [SRC_W-1:0]       w_pick;
  logic [SRC_W:0]         w_sum;
  logic [SRC_W-1:0]       w_idx;
  logic [SRC_W:0]         w_pick_inc;
  logic                   w_fill;
  logic                   w_start;
  logic                   w_grant_valid;
  logic [INPUT_WIDTH-1:0] w_grant_data;
  logic                   w_last;
  logic                   w_hs;
  logic                   w_complete;
  logic                   w_pop;
  logic                   w_underflow;

  // Round-robin search starting at r_rr_ptr; the sum never exceeds 2*NUM_SRC-2 so one subtract wraps it.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (SRC_W + 1)'(k);
      if (w_sum >= NUM_SRC_W) begin
        w_sum = w_sum - NUM_SRC_W;
      end
      w_idx = w_sum[SRC_W-1:0];
      if (!w_found && bus.src_valid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign w_pick_inc = {1'b0, w_pick} + (SRC_W + 1)'(1);

  always_comb begin
    w_grant_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_grant == SRC_W'(i)) begin
        w_grant_data = bus.src_data[i*INPUT_WIDTH +: INPUT_WIDTH];
      end
    end
  end

  assign w_grant_valid = bus.src_valid[r_grant];
  assign w_fill        = (r_state == S_FILL);
  assign w_start       = (r_state == S_IDLE) && w_found && (r_banks_busy != 2'd2);
  assign w_last        = (r_word_cnt == LAST_CNT);
  assign w_hs          = w_fill && w_grant_valid;
  assign w_complete    = w_hs && w_last;
  assign w_pop         = bus.pk_frame_done && (r_banks_busy != 2'd0);
  assign w_underflow   = bus.pk_frame_done && (r_banks_busy == 2'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_start)    w_next_state = S_FILL;
      S_FILL:  if (w_complete) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Ready comes from registered grant only, so there is no valid->ready path.
  always_comb begin
    bus.src_ready = '0;
    bus.pk_valid  = 1'b0;
    bus.pk_data   = '0;
    bus.pk_sof    = 1'b0;
    bus.pk_eof    = 1'b0;
    if (w_fill) begin
      bus.src_ready[r_grant] = 1'b1;
      bus.pk_valid           = w_grant_valid;
      bus.pk_data            = w_grant_data;
      bus.pk_sof             = w_grant_valid && (r_word_cnt == '0);
      bus.pk_eof             = w_grant_valid && w_last;
    end
  end

  assign bus.drain_id_valid = (r_banks_busy != 2'd0);
  assign bus.drain_src_id   = r_fifo_head;
  assign bus.banks_busy     = r_banks_busy;
  assign bus.err_underflow  = r_err_underflow;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_word_cnt <= '0;
    end else if (w_start) begin
      r_grant    <= w_pick;
      r_rr_ptr   <= (w_pick_inc == NUM_SRC_W) ? '0 : w_pick_inc[SRC_W-1:0];
      r_word_cnt <= '0;
    end else if (w_hs) begin
      r_word_cnt <= w_last ? '0 : r_word_cnt + CNT_W'(1);
    end
  end

  // A frame can only be filling while at most one bank is busy, so push+pop sees banks_busy==1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_banks_busy    <= 2'd0;
      r_fifo_head     <= '0;
      r_fifo_tail     <= '0;
      r_err_underflow <= 1'b0;
    end else begin
      if (w_complete && w_pop) begin
        r_fifo_head <= (r_banks_busy == 2'd1) ? r_grant : r_fifo_tail;
        r_fifo_tail <= r_grant;
      end else if (w_complete) begin
        if (r_banks_busy == 2'd0) begin
          r_fifo_head <= r_grant;
        end else begin
          r_fifo_tail <= r_grant;
        end
        r_banks_busy <= r_banks_busy + 2'd1;
      end else if (w_pop) begin
        r_fifo_head  <= r_fifo_tail;
        r_banks_busy <= r_banks_busy - 2'd1;
      end
      if (w_underflow) begin
        r_err_underflow <= 1'b1;
      end
    end
  end

endmodule
